// File: rtl/row_compressor_stream.sv
// Streaming row compressor: accepts one row per handshake and emits its non-zero words, lowest index first.
// Optional ROW_COMPRESSOR_ZERO_BEAT_EN: an all-zero row emits a single zero beat instead of no beat.
module row_compressor_stream #(
    parameter int WORD_WIDTH   = 8,
    parameter int MAX_R_SIZE   = 4,
    parameter int R_DIST_WIDTH = 2,
    parameter int R_CNT_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH*MAX_R_SIZE-1:0] data_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_WIDTH-1:0]            data_out,
    output logic [R_DIST_WIDTH-1:0]          idx_out,
    output logic                             out_last,
    output logic [R_CNT_WIDTH-1:0]           nz_count,
    output logic                             row_empty
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state_reg;
    logic [WORD_WIDTH-1:0]   row_reg [MAX_R_SIZE];
    logic [WORD_WIDTH-1:0]   in_word [MAX_R_SIZE];
    logic [MAX_R_SIZE-1:0]   in_mask;
    logic [MAX_R_SIZE-1:0]   mask_reg;
    logic [MAX_R_SIZE-1:0]   mask_next;
    logic [R_CNT_WIDTH-1:0]  in_count;
    logic [R_CNT_WIDTH-1:0]  nz_count_reg;
    logic                    row_empty_reg;
    logic                    zero_beat_reg;
    logic [R_DIST_WIDTH-1:0] sel_idx;
    logic                    last_one;
    logic                    fire;
    logic                    accept;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_R_SIZE; gi++) begin : g_unpack
            assign in_word[gi] = data_in[WORD_WIDTH*gi +: WORD_WIDTH];
            assign in_mask[gi] = |in_word[gi];
        end
    endgenerate

    always_comb begin
        in_count = '0;
        for (int i = 0; i < MAX_R_SIZE; i++) begin
            in_count = in_count + R_CNT_WIDTH'(in_mask[i]);
        end
    end

    // Priority detector: scanning downward leaves the lowest set bit selected.
    always_comb begin
        sel_idx = '0;
        for (int i = MAX_R_SIZE - 1; i >= 0; i--) begin
            if (mask_reg[i]) begin
                sel_idx = R_DIST_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit also tells us whether it was the only one left.
    assign mask_next = mask_reg & (mask_reg - MAX_R_SIZE'(1));
    assign last_one  = (mask_reg != '0) && (mask_next == '0);

    assign out_valid = (state_reg == DRAIN);
    assign out_last  = out_valid && (zero_beat_reg || last_one);
    assign data_out  = out_valid ? row_reg[sel_idx] : '0;
    assign idx_out   = out_valid ? sel_idx : '0;
    assign fire      = out_valid && out_ready;
    assign in_ready  = (state_reg == IDLE) || (fire && out_last);
    assign accept    = in_valid && in_ready;
    assign nz_count  = nz_count_reg;
    assign row_empty = row_empty_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mask_reg      <= '0;
            nz_count_reg  <= '0;
            row_empty_reg <= 1'b0;
            zero_beat_reg <= 1'b0;
            for (int i = 0; i < MAX_R_SIZE; i++) begin
                row_reg[i] <= '0;
            end
        end else begin
            row_empty_reg <= 1'b0;
            if (accept) begin
                // Covers both IDLE accepts and the overlap with the last beat of the previous row.
                for (int i = 0; i < MAX_R_SIZE; i++) begin
                    row_reg[i] <= in_word[i];
                end
                mask_reg     <= in_mask;
                nz_count_reg <= in_count;
                if (in_mask != '0) begin
                    state_reg     <= DRAIN;
                    zero_beat_reg <= 1'b0;
                end else begin
                    row_empty_reg <= 1'b1;
`ifdef ROW_COMPRESSOR_ZERO_BEAT_EN
                    state_reg     <= DRAIN;
                    zero_beat_reg <= 1'b1;
`else
                    state_reg     <= IDLE;
                    zero_beat_reg <= 1'b0;
`endif
                end
            end else if (fire) begin
                mask_reg      <= mask_next;
                zero_beat_reg <= 1'b0;
                if (out_last) begin
                    state_reg <= IDLE;
                end
            end
        end
    end

endmodule
